// File: rtl/bcd2_to_bin.sv
// Two-digit packed BCD plus decimal carry (0..199) to 8-bit binary.
// Reverse double-dabble: one right shift with subtract-3 correction per clock.
module bcd2_to_bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bcd_in,
  input  logic       carry_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] bin_out,
  output logic       err
);

  localparam int unsigned BinW   = 8;
  localparam int unsigned BcdW   = 12;
  localparam int unsigned CntW   = 3;
  localparam int unsigned DigW   = 4;
  localparam int unsigned NumDig = BcdW / DigW;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BinW-1:0]   bin_q, bin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BinW-1:0]   bin_out_q, bin_out_d;
  logic              err_q, err_d;

  logic [BcdW+BinW-1:0] shift_c;
  logic [BcdW-1:0]      bcd_corr_c;
  logic [BinW-1:0]      bin_shift_c;
  logic                 digits_ok_c;
  logic                 last_c;

  assign digits_ok_c = (bcd_in[7:4] <= 4'd9) && (bcd_in[3:0] <= 4'd9);
  assign last_c      = (cnt_q == CntW'(7));

  // One reverse double-dabble step: shift right, then pull each digit >= 8 back by 3.
  always_comb begin
    shift_c     = {bcd_q, bin_q} >> 1;
    bin_shift_c = shift_c[BinW-1:0];
    bcd_corr_c  = shift_c[BcdW+BinW-1:BinW];
    for (int i = 0; i < NumDig; i++) begin
      if (bcd_corr_c[i*DigW +: DigW] >= DigW'(8)) begin
        bcd_corr_c[i*DigW +: DigW] = bcd_corr_c[i*DigW +: DigW] - DigW'(3);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && digits_ok_c) state_d = CONV;
      CONV: if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; invalid digits report immediately without converting.
  always_comb begin
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!digits_ok_c) begin
            bin_out_d = '0;
            err_d     = 1'b1;
            done_d    = 1'b1;
          end else begin
            bcd_d  = {3'b000, carry_in, bcd_in};
            bin_d  = '0;
            cnt_d  = '0;
            err_d  = 1'b0;
            busy_d = 1'b1;
          end
        end
      end
      CONV: begin
        bcd_d = bcd_corr_c;
        bin_d = bin_shift_c;
        cnt_d = CntW'(cnt_q + CntW'(1));
        if (last_c) begin
          bin_out_d = bin_shift_c;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd2_to_bin.sv
// Directed bench for bcd2_to_bin: latency, error path, ignored starts,
// back-to-back, mid-conversion reset and an exhaustive sweep of all inputs.
module tb_bcd2_to_bin;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bcd_in;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic [7:0] bin_out;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  bcd2_to_bin dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bcd_in   (bcd_in),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .bin_out  (bin_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done after an accepted start; returns cycles from accept (E0) to done.
  task automatic wait_done(output int cyc, output logic saw_busy_drop);
    cyc = 0;
    saw_busy_drop = 1'b0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (done) break;
      if (!busy) saw_busy_drop = 1'b1;
    end
  endtask

  task automatic conv(input string tag, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_bin, input logic exp_err);
    int   cyc;
    logic drop;
    bcd_in   = b;
    carry_in = c;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    bcd_in   = 8'hFF;
    carry_in = 1'b0;
    if (exp_err) begin
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_bin"}, 32'(bin_out), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      tick();
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
    end else begin
      chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
      wait_done(cyc, drop);
      chk({tag, "_lat"}, 32'(cyc), 32'd8);
      chk({tag, "_busy_hold"}, 32'(drop), 32'd0);
      chk({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_busy_e8"}, 32'(busy), 32'd0);
      tick();
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int   cyc;
    int   ndone;
    logic drop;

    rst = 1'b1; start = 1'b0; bcd_in = 8'h00; carry_in = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    conv("c72", 8'h72, 1'b0, 8'h48, 1'b0);
    conv("c199", 8'h99, 1'b1, 8'hC7, 1'b0);
    conv("c100", 8'h00, 1'b1, 8'h64, 1'b0);
    conv("c0", 8'h00, 1'b0, 8'h00, 1'b0);
    conv("bad3A", 8'h3A, 1'b0, 8'h00, 1'b1);
    conv("c45", 8'h45, 1'b0, 8'h2D, 1'b0);

    // Starts during conversion are ignored.
    bcd_in = 8'h72; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    tick();
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      bcd_in = 8'h11; start = 1'b1;
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    wait_done(cyc, drop);
    chk("ign_lat", 32'(cyc + 4), 32'd8);
    chk("ign_bin", 32'(bin_out), 32'h48);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("ign_single", 32'(ndone), 32'd0);

    // Start held through done: second conversion with no idle gap.
    bcd_in = 8'h72; carry_in = 1'b0; start = 1'b1;
    tick();
    wait_done(cyc, drop);
    chk("b2b_lat1", 32'(cyc), 32'd8);
    chk("b2b_bin1", 32'(bin_out), 32'h48);
    bcd_in = 8'h45;
    tick();
    start = 1'b0;
    chk("b2b_busy2", 32'(busy), 32'd1);
    chk("b2b_done_clr", 32'(done), 32'd0);
    wait_done(cyc, drop);
    chk("b2b_lat2", 32'(cyc), 32'd8);
    chk("b2b_bin2", 32'(bin_out), 32'h2D);
    tick();

    // Reset on the 4th conversion edge aborts without a done.
    bcd_in = 8'h72; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bin", 32'(bin_out), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    start = 1'b1; bcd_in = 8'h56;
    tick();
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_quiet", 32'(ndone), 32'd0);
    conv("c56", 8'h56, 1'b0, 8'h38, 1'b0);

    // Exhaustive sweep of every digit combination.
    for (int c = 0; c < 2; c++) begin
      for (int t = 0; t < 16; t++) begin
        for (int u = 0; u < 16; u++) begin
          if (t > 9 || u > 9)
            conv("sweep_bad", 8'((t << 4) | u), 1'(c), 8'h00, 1'b1);
          else
            conv("sweep", 8'((t << 4) | u), 1'(c), 8'(100 * c + 10 * t + u), 1'b0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
